// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the RIM/UPC strobes and branch select of the fetch unit and
// issues fetched instructions downstream, handling stall, branch redirect and stop-halt.
module fetch_sequencer #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             stop,
    output logic             rim,
    output logic             upc,
    output logic             br_sel,
    output logic             if_valid,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] issue_count
);

    localparam int unsigned WaitW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StIssue,
        StUpdate,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic               br_pend_q, br_pend_d;
    logic               flush_q, flush_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               redirect;

    // A branch resolved while an instruction is in flight abandons it.
    assign redirect = branch_taken &&
                      (state_q == StRead || state_q == StWait || state_q == StIssue);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            br_pend_q <= 1'b0;
            flush_q   <= 1'b0;
            wait_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            br_pend_q <= br_pend_d;
            flush_q   <= flush_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        br_pend_d = br_pend_q;
        flush_d   = 1'b0;
        wait_d    = wait_q;
        count_d   = count_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRead;
            end
            StRead: begin
                wait_d  = WaitW'(MEM_LAT);
                state_d = StWait;
            end
            StWait: begin
                wait_d = wait_q - WaitW'(1);
                if (wait_q == WaitW'(1)) state_d = StIssue;
            end
            StIssue: begin
                // Stall wins over stop: the halt waits until the stall drops.
                if (!stall) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = stop ? StHalt : StUpdate;
                end
            end
            StUpdate: begin
                br_pend_d = 1'b0;
                state_d   = StRead;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (redirect) begin
            br_pend_d = 1'b1;
            flush_d   = 1'b1;
            count_d   = count_q;
            state_d   = StUpdate;
        end
    end

    assign rim         = (state_q == StRead);
    assign upc         = (state_q == StUpdate);
    assign br_sel      = (state_q == StUpdate) && (br_pend_q || branch_taken);
    assign if_valid    = (state_q == StIssue) && !br_pend_q && !branch_taken;
    assign halted      = (state_q == StHalt);
    assign flush       = flush_q;
    assign issue_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (MEM_LAT 1 and 4) driven by shared random
// stimulus, checked per cycle against a phase-based reference model via scoreboards.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst, start, stall, branch_taken, stop;

    logic        rim0, upc0, bsel0, val0, flush0, halt0;
    logic        rim1, upc1, bsel1, val1, flush1, halt1;
    logic [15:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    logic [21:0] q0[$];
    logic [21:0] q1[$];

    // Reference model: position within one fetch round of length 3+L
    // (0 = read strobe, 1..L = memory wait, L+1 = issue, L+2 = PC update).
    int          lat    [2] = '{1, 4};
    int          m_mode [2];   // 0 idle, 1 fetching, 2 halted
    int          m_phase[2];
    bit          m_pend [2];
    bit          m_flush[2];
    int unsigned m_cnt  [2];

    always #5 clk = ~clk;

    fetch_sequencer #(.MEM_LAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .branch_taken(branch_taken), .stop(stop),
        .rim(rim0), .upc(upc0), .br_sel(bsel0), .if_valid(val0),
        .flush(flush0), .halted(halt0), .issue_count(cnt0)
    );

    fetch_sequencer #(.MEM_LAT(4), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .branch_taken(branch_taken), .stop(stop),
        .rim(rim1), .upc(upc1), .br_sel(bsel1), .if_valid(val1),
        .flush(flush1), .halted(halt1), .issue_count(cnt1)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]  = 0;
            m_phase[i] = 0;
            m_pend[i]  = 1'b0;
            m_flush[i] = 1'b0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic model_step(input int i, input bit st, input bit sl, input bit bt,
                              input bit sp, output logic [21:0] exp);
        int l;
        bit rim_e, upc_e, val_e, bsel_e;
        l      = lat[i];
        rim_e  = (m_mode[i] == 1) && (m_phase[i] == 0);
        upc_e  = (m_mode[i] == 1) && (m_phase[i] == l + 2);
        val_e  = (m_mode[i] == 1) && (m_phase[i] == l + 1) && !m_pend[i] && !bt;
        bsel_e = upc_e && (m_pend[i] || bt);
        exp = {rim_e, upc_e, bsel_e, val_e, m_flush[i], (m_mode[i] == 2),
               16'(m_cnt[i] % 65536)};
        m_flush[i] = 1'b0;
        if (m_mode[i] == 0) begin
            if (st) begin
                m_mode[i]  = 1;
                m_phase[i] = 0;
            end
        end else if (m_mode[i] == 1) begin
            if (m_phase[i] <= l + 1 && bt) begin
                m_pend[i]  = 1'b1;
                m_flush[i] = 1'b1;
                m_phase[i] = l + 2;
            end else if (m_phase[i] == l + 1) begin
                if (!sl) begin
                    m_cnt[i] = (m_cnt[i] + 1) % 65536;
                    if (sp) m_mode[i] = 2;
                    else    m_phase[i] = l + 2;
                end
            end else if (m_phase[i] == l + 2) begin
                m_pend[i]  = 1'b0;
                m_phase[i] = 0;
            end else begin
                m_phase[i] = m_phase[i] + 1;
            end
        end
    endtask

    // One clock cycle of stimulus; expected outputs for that cycle go to the scoreboards.
    task automatic cycle(input bit r, input bit st, input bit sl, input bit bt, input bit sp);
        logic [21:0] e0, e1;
        @(posedge clk);
        #1;
        rst = r; start = st; stall = sl; branch_taken = bt; stop = sp;
        if (r) begin
            model_reset();
            e0 = '0;
            e1 = '0;
            #1;
            tests++;
            if ({rim1, upc1, val1, flush1, halt1, cnt1} != '0) begin
                fails++;
                $display("FAIL async_reset got %h want 0",
                         {rim1, upc1, val1, flush1, halt1, cnt1});
            end
        end else begin
            model_step(0, st, sl, bt, sp, e0);
            model_step(1, st, sl, bt, sp, e1);
        end
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    always @(negedge clk) begin
        logic [21:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            tests++;
            if ({rim0, upc0, bsel0, val0, flush0, halt0, cnt0} != e) begin
                fails++;
                $display("FAIL lat1_outputs t=%0t got %h want %h", $time,
                         {rim0, upc0, bsel0, val0, flush0, halt0, cnt0}, e);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            tests++;
            if ({rim1, upc1, bsel1, val1, flush1, halt1, cnt1} != e) begin
                fails++;
                $display("FAIL lat4_outputs t=%0t got %h want %h", $time,
                         {rim1, upc1, bsel1, val1, flush1, halt1, cnt1}, e);
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; stop = 1'b0;
        model_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Plain streaming, then a stalled first instruction, then an early branch.
        for (int c = 0; c < 13; c++) cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int c = 0; c < 12; c++) cycle(0, (c == 0), (c >= 3 && c <= 6), 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) cycle(0, 1, 0, (c == 2), 0);
        // Stop together with a branch must not halt.
        for (int c = 0; c < 12; c++) cycle(0, 1, 0, (c == 3 || c == 7), (c == 3 || c == 7));

        for (int it = 0; it < 12; it++) begin
            cycle(1, 0, 0, 0, 0);
            for (int c = 0; c < 160; c++) begin
                cycle(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
            end
            // Steer the MEM_LAT=4 instance into its wait phase, then reset mid-wait.
            cycle(1, 0, 0, 0, 0);
            guard = 0;
            while (!(m_mode[1] == 1 && m_phase[1] >= 1 && m_phase[1] <= 4) && guard < 50) begin
                cycle(0, 1, 0, 0, 0);
                guard++;
            end
            tests++;
            if (guard >= 50) begin
                fails++;
                $display("FAIL reach_wait got %0d cycles want <50", guard);
            end
            cycle(0, 1, 0, 0, 0);
            cycle(1, 1, 0, 0, 0);
            for (int c = 0; c < 6; c++) cycle(0, 1, 0, 0, 0);
        end

        cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
